// File: rtl/prod_sched.sv
// Write-side scheduler for the producer-domain side of the clock-crossing FIFO.
// Grants the FIFO write port to the fib or timer producer and keeps every word through stalls.
module prod_sched #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SLICE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [SLICE_W-1:0] slice_len,
  input  logic               f_valid,
  input  logic [DATA_W-1:0]  f_data,
  input  logic               t_valid,
  input  logic [DATA_W-1:0]  t_data,
  input  logic               buffer_full,
  input  logic               buffer_empty,
  input  logic               data_2_valid,
  output logic               f_en,
  output logic               t_en,
  output logic               wr_en,
  output logic [DATA_W-1:0]  wr_data,
  output logic [1:0]         owner,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = SLICE_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT_F = 3'd1,
    S_GRANT_T = 3'd2,
    S_HOLD    = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  state_e               r_state, w_state_nxt;
  logic                 r_was_f, r_was_t, r_hold_t, w_hold_t_nxt;
  logic                 r_rr;
  logic [SLICE_W-1:0]   r_slice_len, r_cnt, w_cnt_nxt;
  logic                 r_skid_vld;
  logic [DATA_W-1:0]    r_skid_data;
  logic                 r_wr_en;
  logic [DATA_W-1:0]    r_wr_data;
  logic                 r_f_en, r_t_en, r_busy, r_done;
  logic [1:0]           r_owner;

  logic                 w_grant_f, w_grant_t, w_tail_f, w_tail_t;
  logic                 w_acc_f, w_acc_t, w_win_f, w_new_vld, w_lose_vld;
  logic [DATA_W-1:0]    w_new_data, w_lose_data;
  logic                 w_wr, w_skid_ld, w_latch;
  logic [DATA_W-1:0]    w_wr_data, w_skid_ld_data;
  logic                 w_cnt_inc, w_slice_end;
  logic [CNT_W-1:0]     w_cnt_sum;
  logic                 w_f_en_nxt, w_t_en_nxt, w_busy_nxt, w_done_nxt;
  logic [1:0]           w_owner_nxt;

  // Word acceptance: granted producer, or its one in-flight word the cycle after the grant ends.
  assign w_grant_f   = (r_state == S_GRANT_F);
  assign w_grant_t   = (r_state == S_GRANT_T);
  assign w_tail_f    = r_was_f & ~w_grant_f;
  assign w_tail_t    = r_was_t & ~w_grant_t;
  assign w_acc_f     = f_valid & (w_grant_f | w_tail_f);
  assign w_acc_t     = t_valid & (w_grant_t | w_tail_t);
  assign w_win_f     = w_acc_f & (~w_acc_t | w_tail_f);
  assign w_new_vld   = w_acc_f | w_acc_t;
  assign w_lose_vld  = w_acc_f & w_acc_t;
  assign w_new_data  = w_win_f ? f_data : t_data;
  assign w_lose_data = w_win_f ? t_data : f_data;

  assign w_cnt_inc   = r_rr & ((w_grant_f & w_acc_f) | (w_grant_t & w_acc_t));
  assign w_cnt_sum   = {1'b0, r_cnt} + CNT_W'(w_cnt_inc);
  assign w_slice_end = r_rr & (w_cnt_sum >= {1'b0, r_slice_len});

  // Write arbitration: skid drains first, losers and stalled words park in the skid.
  always_comb begin
    w_wr           = 1'b0;
    w_wr_data      = r_skid_data;
    w_skid_ld      = 1'b0;
    w_skid_ld_data = w_new_data;
    if (!buffer_full && r_skid_vld) begin
      w_wr      = 1'b1;
      w_skid_ld = w_new_vld;
    end else if (!buffer_full && w_new_vld) begin
      w_wr           = 1'b1;
      w_wr_data      = w_new_data;
      w_skid_ld      = w_lose_vld;
      w_skid_ld_data = w_lose_data;
    end else begin
      w_skid_ld = w_new_vld;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_was_f     <= 1'b0;
      r_was_t     <= 1'b0;
      r_hold_t    <= 1'b0;
      r_rr        <= 1'b0;
      r_slice_len <= '0;
      r_cnt       <= '0;
    end else begin
      r_skid_vld <= w_skid_ld | (r_skid_vld & ~w_wr);
      if (w_skid_ld) r_skid_data <= w_skid_ld_data;
      r_wr_en <= w_wr;
      if (w_wr) r_wr_data <= w_wr_data;
      r_was_f  <= w_grant_f;
      r_was_t  <= w_grant_t;
      r_hold_t <= w_hold_t_nxt;
      r_cnt    <= w_cnt_nxt;
      if (w_latch) begin
        r_rr        <= mode[1];
        r_slice_len <= (slice_len == '0) ? SLICE_W'(1) : slice_len;
      end
    end
  end

  // State register; Moore outputs are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_f_en  <= 1'b0;
      r_t_en  <= 1'b0;
      r_owner <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_f_en  <= w_f_en_nxt;
      r_t_en  <= w_t_en_nxt;
      r_owner <= w_owner_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_t_nxt = r_hold_t;
    w_cnt_nxt    = r_cnt;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = (mode == 2'b01) ? S_GRANT_T : S_GRANT_F;
        end
      end
      S_GRANT_F, S_GRANT_T: begin
        w_cnt_nxt = w_cnt_sum[SLICE_W-1:0];
        if (stop) begin
          w_state_nxt = S_DRAIN;
        end else if (buffer_full) begin
          w_state_nxt  = S_HOLD;
          w_hold_t_nxt = w_grant_t;
        end else if (w_slice_end) begin
          w_state_nxt = w_grant_f ? S_GRANT_T : S_GRANT_F;
          w_cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        if (stop) begin
          w_state_nxt = S_DRAIN;
        end else if (!buffer_full && !r_skid_vld) begin
          w_state_nxt = r_hold_t ? S_GRANT_T : S_GRANT_F;
        end
      end
      S_DRAIN: begin
        if (!r_skid_vld && !w_new_vld && buffer_empty && !data_2_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_f_en_nxt  = (w_state_nxt == S_GRANT_F);
    w_t_en_nxt  = (w_state_nxt == S_GRANT_T);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (r_state == S_DRAIN) && (w_state_nxt == S_IDLE);
    w_owner_nxt = 2'b00;
    case (w_state_nxt)
      S_GRANT_F: w_owner_nxt = 2'b10;
      S_GRANT_T: w_owner_nxt = 2'b01;
      S_HOLD:    w_owner_nxt = w_hold_t_nxt ? 2'b01 : 2'b10;
      default:   w_owner_nxt = 2'b00;
    endcase
  end

  assign f_en    = r_f_en;
  assign t_en    = r_t_en;
  assign wr_en   = r_wr_en;
  assign wr_data = r_wr_data;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_prod_sched.sv
// Directed bench for prod_sched: producers answer their enable in the same cycle,
// a posedge monitor logs FIFO writes, and each task checks its own scenario.
module tb_prod_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  slice_len = 8'd0;
  logic        f_valid, t_valid;
  logic [15:0] f_data, t_data;
  logic        buffer_full = 1'b0, buffer_empty = 1'b1, data_2_valid = 1'b0;
  logic        f_en, t_en, wr_en, busy, done;
  logic [15:0] wr_data;
  logic [1:0]  owner;

  logic        f_gate = 1'b1, t_gate = 1'b1;
  logic        f_ovr = 1'b0;
  logic [15:0] f_ovr_data = 16'h0000;
  logic [15:0] f_seq = 16'h0100;
  logic [15:0] t_seq = 16'h8000;

  int checks = 0;
  int failures = 0;
  logic [15:0] wr_log[$];
  int overlap_cnt = 0, t_en_cnt = 0, ovf_cnt = 0, done_cnt = 0;

  always #5 clk = ~clk;

  assign f_valid = f_ovr | (f_en & f_gate);
  assign f_data  = f_ovr ? f_ovr_data : f_seq;
  assign t_valid = t_en & t_gate;
  assign t_data  = t_seq;

  always @(posedge clk) begin
    if (f_en && f_gate) f_seq <= f_seq + 16'd1;
    if (t_en && t_gate) t_seq <= t_seq + 16'd1;
  end

  always @(posedge clk) begin
    if (wr_en) wr_log.push_back(wr_data);
    if (f_en && t_en) overlap_cnt++;
    if (t_en) t_en_cnt++;
    if (done) done_cnt++;
    if (rst && ((dut.w_acc_f && dut.w_acc_t && (buffer_full || dut.r_skid_vld)) ||
                ((dut.w_acc_f || dut.w_acc_t) && dut.r_skid_vld && buffer_full)))
      ovf_cnt++;
  end

  prod_sched #(.DATA_W(16), .SLICE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .slice_len(slice_len),
    .f_valid(f_valid), .f_data(f_data), .t_valid(t_valid), .t_data(t_data),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty), .data_2_valid(data_2_valid),
    .f_en(f_en), .t_en(t_en), .wr_en(wr_en), .wr_data(wr_data), .owner(owner),
    .busy(busy), .done(done)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b0;
    cyc(2);
    checks++;
    if ({f_en, t_en, wr_en, wr_data, owner, busy, done} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {f_en, t_en, wr_en, wr_data, owner, busy, done});
    end
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if ({f_en, t_en, wr_en, wr_data, owner, busy, done} !== 23'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL idle_quiet nonzero_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_fib_single();
    int base, t0c;
    logic [15:0] f0;
    mode = 2'b00; slice_len = 8'd0;
    base = wr_log.size(); f0 = f_seq; t0c = t_en_cnt;
    start = 1'b1; cyc(1); start = 1'b0;
    checks++;
    if ({f_en, t_en, owner, busy} !== 5'b10101) begin
      failures++;
      $display("FAIL fib_grant got=%b exp=10101", {f_en, t_en, owner, busy});
    end
    cyc(9); stop = 1'b1; cyc(1); stop = 1'b0;
    checks++;
    if ({f_en, owner, busy, done} !== 5'b00010) begin
      failures++;
      $display("FAIL fib_drain got=%b exp=00010", {f_en, owner, busy, done});
    end
    cyc(1);
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++;
      $display("FAIL fib_done_pulse got=%b exp=10", {done, busy});
    end
    cyc(1);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL fib_done_width got=%b exp=0", done);
    end
    cyc(2);
    checks++;
    if (wr_log.size() - base !== 10) begin
      failures++;
      $display("FAIL fib_count got=%0d exp=10", wr_log.size() - base);
    end
    for (int i = 0; i < 10; i++) begin
      if (base + i < wr_log.size()) begin
        checks++;
        if (wr_log[base + i] !== 16'(f0 + 16'(i))) begin
          failures++;
          $display("FAIL fib_word[%0d] got=%h exp=%h", i, wr_log[base + i], 16'(f0 + 16'(i)));
        end
      end
    end
    checks++;
    if (t_en_cnt - t0c !== 0) begin
      failures++;
      $display("FAIL fib_t_en_seen got=%0d exp=0", t_en_cnt - t0c);
    end
  endtask

  task automatic test_round_robin();
    int base, s, k;
    logic [15:0] f0, t0, exp_w;
    mode = 2'b10; slice_len = 8'd3;
    base = wr_log.size(); f0 = f_seq; t0 = t_seq;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(2);
    checks++;
    if ({f_en, t_en} !== 2'b10) begin
      failures++;
      $display("FAIL rr_first_slice got=%b exp=10", {f_en, t_en});
    end
    cyc(1);
    checks++;
    if ({f_en, t_en, owner} !== 4'b0101) begin
      failures++;
      $display("FAIL rr_switch got=%b exp=0101", {f_en, t_en, owner});
    end
    cyc(16); stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(4);
    checks++;
    if (wr_log.size() - base !== 20) begin
      failures++;
      $display("FAIL rr_count got=%0d exp=20", wr_log.size() - base);
    end
    for (int j = 0; j < 20; j++) begin
      s = j / 3;
      k = (s / 2) * 3 + (j % 3);
      exp_w = (s % 2 == 0) ? 16'(f0 + 16'(k)) : 16'(t0 + 16'(k));
      if (base + j < wr_log.size()) begin
        checks++;
        if (wr_log[base + j] !== exp_w) begin
          failures++;
          $display("FAIL rr_word[%0d] got=%h exp=%h", j, wr_log[base + j], exp_w);
        end
      end
    end
  endtask

  task automatic test_hold();
    int base;
    logic [15:0] t0;
    mode = 2'b01; slice_len = 8'd2;
    base = wr_log.size(); t0 = t_seq;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4); buffer_full = 1'b1; cyc(1);
    checks++;
    if ({t_en, owner, busy, dut.r_skid_vld} !== 5'b00111) begin
      failures++;
      $display("FAIL hold_enter got=%b exp=00111", {t_en, owner, busy, dut.r_skid_vld});
    end
    cyc(4);
    checks++;
    if ({wr_en, t_en, owner} !== 4'b0001) begin
      failures++;
      $display("FAIL hold_stall got=%b exp=0001", {wr_en, t_en, owner});
    end
    cyc(15); buffer_full = 1'b0; cyc(1);
    checks++;
    if ({wr_en, t_en, wr_data} !== {1'b1, 1'b0, 16'(t0 + 16'd4)}) begin
      failures++;
      $display("FAIL hold_skid_first got=%b/%b/%h exp=1/0/%h", wr_en, t_en, wr_data, 16'(t0 + 16'd4));
    end
    cyc(1);
    checks++;
    if (t_en !== 1'b1) begin
      failures++;
      $display("FAIL hold_resume got=%b exp=1", t_en);
    end
    cyc(3); stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(4);
    checks++;
    if (wr_log.size() - base !== 9) begin
      failures++;
      $display("FAIL hold_count got=%0d exp=9", wr_log.size() - base);
    end
    for (int i = 0; i < 9; i++) begin
      if (base + i < wr_log.size()) begin
        checks++;
        if (wr_log[base + i] !== 16'(t0 + 16'(i))) begin
          failures++;
          $display("FAIL hold_word[%0d] got=%h exp=%h", i, wr_log[base + i], 16'(t0 + 16'(i)));
        end
      end
    end
  endtask

  task automatic test_stop_drain();
    int d0;
    mode = 2'b00; buffer_empty = 1'b0; data_2_valid = 1'b1;
    d0 = done_cnt;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(3); stop = 1'b1; cyc(1); stop = 1'b0;
    checks++;
    if ({f_en, owner, busy} !== 4'b0001) begin
      failures++;
      $display("FAIL drain_enter got=%b exp=0001", {f_en, owner, busy});
    end
    f_ovr = 1'b1; f_ovr_data = 16'h5555;
    cyc(1); f_ovr = 1'b0;
    checks++;
    if ({wr_en, wr_data} !== {1'b1, 16'h5555}) begin
      failures++;
      $display("FAIL drain_tail got=%b/%h exp=1/5555", wr_en, wr_data);
    end
    cyc(2);
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL drain_wait_empty got=%b exp=10", {busy, done});
    end
    buffer_empty = 1'b1; cyc(1);
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL drain_wait_d2v got=%b exp=10", {busy, done});
    end
    data_2_valid = 1'b0; cyc(1);
    checks++;
    if ({busy, done} !== 2'b01) begin
      failures++;
      $display("FAIL drain_done got=%b exp=01", {busy, done});
    end
    cyc(1);
    checks++;
    if ({busy, done} !== 2'b00 || done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL drain_idle got=%b pulses=%0d exp=00/1", {busy, done}, done_cnt - d0);
    end
  endtask

  task automatic test_contention();
    int base;
    logic [15:0] f0, t0;
    logic [15:0] exp_q[6];
    mode = 2'b10; slice_len = 8'd0;
    base = wr_log.size(); f0 = f_seq; t0 = t_seq;
    exp_q = '{f0, 16'hAAAA, t0, 16'(f0 + 16'd1), 16'(t0 + 16'd1), 16'(f0 + 16'd2)};
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    checks++;
    if ({f_en, t_en} !== 2'b01) begin
      failures++;
      $display("FAIL cont_slice_one got=%b exp=01", {f_en, t_en});
    end
    f_ovr = 1'b1; f_ovr_data = 16'hAAAA;
    cyc(1); f_ovr = 1'b0;
    checks++;
    if ({wr_en, wr_data, dut.r_skid_vld} !== {1'b1, 16'hAAAA, 1'b1}) begin
      failures++;
      $display("FAIL cont_tail_wins got=%b/%h/%b exp=1/aaaa/1", wr_en, wr_data, dut.r_skid_vld);
    end
    cyc(1);
    checks++;
    if (wr_data !== t0) begin
      failures++;
      $display("FAIL cont_loser_next got=%h exp=%h", wr_data, t0);
    end
    cyc(1); stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(4);
    checks++;
    if (wr_log.size() - base !== 6) begin
      failures++;
      $display("FAIL cont_count got=%0d exp=6", wr_log.size() - base);
    end
    for (int i = 0; i < 6; i++) begin
      if (base + i < wr_log.size()) begin
        checks++;
        if (wr_log[base + i] !== exp_q[i]) begin
          failures++;
          $display("FAIL cont_word[%0d] got=%h exp=%h", i, wr_log[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_start_stop();
    mode = 2'b01;
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    checks++;
    if ({t_en, busy} !== 2'b11) begin
      failures++;
      $display("FAIL start_beats_stop got=%b exp=11", {t_en, busy});
    end
    mode = 2'b00; start = 1'b1; cyc(1); start = 1'b0;
    checks++;
    if ({f_en, t_en} !== 2'b01) begin
      failures++;
      $display("FAIL start_while_busy got=%b exp=01", {f_en, t_en});
    end
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(3);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_stop_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_rst_mid_drain();
    int base;
    logic [15:0] f1;
    mode = 2'b00;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1); buffer_full = 1'b1;
    cyc(1); stop = 1'b1;
    cyc(1); stop = 1'b0;
    checks++;
    if ({busy, owner, dut.r_skid_vld} !== 4'b1001) begin
      failures++;
      $display("FAIL rst_pre_state got=%b exp=1001", {busy, owner, dut.r_skid_vld});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({f_en, t_en, wr_en, wr_data, owner, busy, done} !== 23'd0) begin
      failures++;
      $display("FAIL rst_async got=%h exp=0", {f_en, t_en, wr_en, wr_data, owner, busy, done});
    end
    cyc(1); rst = 1'b1; buffer_full = 1'b0;
    cyc(2);
    base = wr_log.size(); f1 = f_seq;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(2); stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(4);
    checks++;
    if (wr_log.size() - base !== 3) begin
      failures++;
      $display("FAIL rst_restart_count got=%0d exp=3", wr_log.size() - base);
    end
    if (base < wr_log.size()) begin
      checks++;
      if (wr_log[base] !== f1) begin
        failures++;
        $display("FAIL rst_no_stale got=%h exp=%h", wr_log[base], f1);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap_cnt !== 0) begin
      failures++;
      $display("FAIL enable_overlap got=%0d exp=0", overlap_cnt);
    end
    checks++;
    if (ovf_cnt !== 0) begin
      failures++;
      $display("FAIL skid_overflow got=%0d exp=0", ovf_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fib_single();
    test_round_robin();
    test_hold();
    test_stop_drain();
    test_contention();
    test_start_stop();
    test_rst_mid_drain();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
